// File: rtl/seq_check_pkg.sv
// seq_check_pkg: shared state encoding, default pattern and count-width helper
package seq_check_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} state_t;
  localparam logic [3:0] PAT_DEFAULT = 4'b1011;
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: overlapping serial pattern matcher with history and fill tracking
module seq_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] window;
  assign window = {hist, bit_in};
  assign match  = bit_vld && fill >= FW'(PAT_W - 1) && window == pattern;
  // only the previous PAT_W-1 bits are kept; the window is completed by the live bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_vld) begin
      hist <= window[PAT_W-2:0];
      fill <= fill == FW'(PAT_W) ? fill : fill + 1'b1;
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts words, scans them MSB-first through the matcher, reports match counts
module seq_scan_ctrl
  import seq_check_pkg::*;
#(
  parameter int               WORD_W  = 16,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT),
  localparam int              CNT_W   = cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              cfg_keep,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy,
  output logic              ser_bit,
  output logic              match
);
  localparam int IW = $clog2(WORD_W);
  state_t            state;
  logic [WORD_W-1:0] word;
  logic [IW-1:0]     bit_idx;
  logic [CNT_W-1:0]  cnt;
  logic [PAT_W-1:0]  pattern;
  logic              cur_bit;
  logic              hit;
  logic              clr;
  assign cur_bit  = word[bit_idx];
  assign clr      = state == IDLE && in_valid && !cfg_keep;
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bit_vld (state == SHIFT),
    .bit_in  (cur_bit),
    .pattern (pattern),
    .match   (hit)
  );
  // word sequencing: accept in IDLE, one bit per edge in SHIFT, hold result in REPORT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      bit_idx   <= '0;
      cnt       <= '0;
      pattern   <= PAT_RST;
      out_valid <= 1'b0;
      out_count <= '0;
      ser_bit   <= 1'b0;
      match     <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) pattern <= cfg_pat;
          if (in_valid) begin
            word    <= in_data;
            bit_idx <= IW'(WORD_W - 1);
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          ser_bit <= cur_bit;
          match   <= hit;
          cnt     <= cnt + CNT_W'(hit);
          if (bit_idx == '0) begin
            out_count <= cnt + CNT_W'(hit);
            out_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
